i8088_bus_ctrl: RTL and testbench

Minimum-mode 8088 bus-cycle sequencer. It converts single-byte memory/IO transfer requests from the processor execution logic into T1–T4 bus cycles on the Intel8088Pins signal set. It generates ALE, RD/WR strobes, IO/M, DT/R and DEN, and inserts wait states from READY. It also arbitrates bus ownership with an external master through HOLD/HLDA.

---
 rtl/i8088_bus_ctrl_if.sv | 42 ++++
 rtl/i8088_bus_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_i8088_bus_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i8088_bus_ctrl_if.sv
// Processor-side request/response and 8088 minimum-mode pin bundle.
// The master modport is the bus controller; slave is its environment.
interface i8088_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_rdy;
    logic              req_wr;
    logic              req_io;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ack;
    logic              timeout;
    logic [DATA_W-1:0] rdata;
    logic              ale;
    logic              rd_n;
    logic              wr_n;
    logic              iom;
    logic              dtr;
    logic              den;
    logic [ADDR_W-9:0] addr_hi;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_in;
    logic              bus_oe;
    logic              ready;
    logic              hold;
    logic              hlda;

    modport master (
        input  req_valid, req_wr, req_io, req_addr, req_wdata, ad_in, ready, hold,
        output req_rdy, ack, timeout, rdata, ale, rd_n, wr_n, iom, dtr, den,
               addr_hi, ad_out, ad_oe, bus_oe, hlda
    );

    modport slave (
        output req_valid, req_wr, req_io, req_addr, req_wdata, ad_in, ready, hold,
        input  req_rdy, ack, timeout, rdata, ale, rd_n, wr_n, iom, dtr, den,
               addr_hi, ad_out, ad_oe, bus_oe, hlda
    );
endinterface

// File: rtl/i8088_bus_ctrl.sv
// Minimum-mode 8088 bus-cycle sequencer: turns single-byte requests into
// T1..T4 cycles with READY wait states and HOLD/HLDA bus hand-over.
module i8088_bus_ctrl #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic            clk,
    input logic            reset,
    i8088_bus_ctrl_if.master bus
);
    localparam int unsigned HI_W  = ADDR_W - 8;
    localparam int unsigned CNT_W = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_TW   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_HLD  = 3'd6;

    logic [2:0]        state, state_nx;
    logic [CNT_W-1:0]  wcnt, wcnt_nx;
    logic              tmo, tmo_nx;
    logic              wr_q, wr_nx, io_q, io_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [DATA_W-1:0] rdata_q, rdata_nx;

    logic              ale_q, ale_nx, rd_n_q, rd_n_nx, wr_n_q, wr_n_nx;
    logic              den_q, den_nx, ad_oe_q, ad_oe_nx, iom_q, iom_nx, dtr_q, dtr_nx;
    logic              ack_q, ack_nx, timeout_q, timeout_nx;
    logic              hlda_q, hlda_nx, bus_oe_q, bus_oe_nx;
    logic [HI_W-1:0]   addr_hi_q, addr_hi_nx;
    logic [DATA_W-1:0] ad_out_q, ad_out_nx;

    logic              req_rdy_c, accept_c;

    // Ready must follow HOLD in the same cycle so a request is never taken while the bus is being surrendered.
    assign req_rdy_c = !reset && !bus.hold && (state == S_IDLE || state == S_T4);
    assign accept_c  = bus.req_valid && req_rdy_c;

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        tmo_nx   = tmo;
        wr_nx    = wr_q;
        io_nx    = io_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        rdata_nx = rdata_q;

        if (accept_c) begin
            wr_nx    = bus.req_wr;
            io_nx    = bus.req_io;
            addr_nx  = bus.req_addr;
            wdata_nx = bus.req_wdata;
            tmo_nx   = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (bus.hold)    state_nx = S_HLD;
                else if (accept_c) state_nx = S_T1;
            end
            S_T1: state_nx = S_T2;
            S_T2: state_nx = S_T3;
            S_T3, S_TW: begin
                if (bus.ready) begin
                    state_nx = S_T4;
                    if (!wr_q) rdata_nx = bus.ad_in;
                end else if (wcnt == CNT_W'(MAX_WAIT)) begin
                    state_nx = S_T4;
                    tmo_nx   = 1'b1;
                    if (!wr_q) rdata_nx = {DATA_W{1'b1}};
                end else begin
                    state_nx = S_TW;
                    wcnt_nx  = wcnt + CNT_W'(1);
                end
            end
            S_T4: begin
                wcnt_nx = '0;
                if (bus.hold)      state_nx = S_HLD;
                else if (accept_c) state_nx = S_T1;
                else               state_nx = S_IDLE;
            end
            S_HLD: if (!bus.hold) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Pin values for the cycle about to start, so every pin leaves a flop.
        ale_nx     = 1'b0;
        rd_n_nx    = 1'b1;
        wr_n_nx    = 1'b1;
        den_nx     = 1'b1;
        ad_oe_nx   = 1'b0;
        ack_nx     = 1'b0;
        timeout_nx = 1'b0;
        hlda_nx    = 1'b0;
        bus_oe_nx  = 1'b1;
        iom_nx     = iom_q;
        dtr_nx     = dtr_q;
        addr_hi_nx = addr_hi_q;
        ad_out_nx  = ad_out_q;

        case (state_nx)
            S_T1: begin
                ale_nx     = 1'b1;
                addr_hi_nx = addr_nx[ADDR_W-1:8];
                ad_out_nx  = DATA_W'(addr_nx[7:0]);
                ad_oe_nx   = 1'b1;
                iom_nx     = io_nx;
                dtr_nx     = wr_nx;
            end
            S_T2, S_T3, S_TW: begin
                den_nx = 1'b0;
                if (wr_nx) begin
                    ad_out_nx = wdata_nx;
                    ad_oe_nx  = 1'b1;
                    wr_n_nx   = 1'b0;
                end else begin
                    rd_n_nx = 1'b0;
                end
            end
            S_T4: begin
                ack_nx     = 1'b1;
                timeout_nx = tmo_nx;
            end
            S_HLD: begin
                hlda_nx   = 1'b1;
                bus_oe_nx = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            tmo       <= 1'b0;
            wr_q      <= 1'b0;
            io_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ale_q     <= 1'b0;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            den_q     <= 1'b1;
            ad_oe_q   <= 1'b0;
            iom_q     <= 1'b0;
            dtr_q     <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            hlda_q    <= 1'b0;
            bus_oe_q  <= 1'b1;
            addr_hi_q <= '0;
            ad_out_q  <= '0;
        end else begin
            state     <= state_nx;
            wcnt      <= wcnt_nx;
            tmo       <= tmo_nx;
            wr_q      <= wr_nx;
            io_q      <= io_nx;
            addr_q    <= addr_nx;
            wdata_q   <= wdata_nx;
            rdata_q   <= rdata_nx;
            ale_q     <= ale_nx;
            rd_n_q    <= rd_n_nx;
            wr_n_q    <= wr_n_nx;
            den_q     <= den_nx;
            ad_oe_q   <= ad_oe_nx;
            iom_q     <= iom_nx;
            dtr_q     <= dtr_nx;
            ack_q     <= ack_nx;
            timeout_q <= timeout_nx;
            hlda_q    <= hlda_nx;
            bus_oe_q  <= bus_oe_nx;
            addr_hi_q <= addr_hi_nx;
            ad_out_q  <= ad_out_nx;
        end
    end

    assign bus.req_rdy = req_rdy_c;
    assign bus.ack     = ack_q;
    assign bus.timeout = timeout_q;
    assign bus.rdata   = rdata_q;
    assign bus.ale     = ale_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.wr_n    = wr_n_q;
    assign bus.iom     = iom_q;
    assign bus.dtr     = dtr_q;
    assign bus.den     = den_q;
    assign bus.addr_hi = addr_hi_q;
    assign bus.ad_out  = ad_out_q;
    assign bus.ad_oe   = ad_oe_q;
    assign bus.bus_oe  = bus_oe_q;
    assign bus.hlda    = hlda_q;
endmodule

// File: tb/tb_i8088_bus_ctrl.sv
// Self-checking bench for i8088_bus_ctrl: directed vectors, HOLD/back-to-back/reset
// sequences, randomized transfers against a phase-level model, and a MAX_WAIT=0 instance.
module tb_i8088_bus_ctrl;
    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAX_WAIT = 15;
    localparam logic [31:0] RESET_CTRL = 32'h702;

    typedef enum int {P_IDLE, P_T1, P_T2, P_WAIT, P_T4, P_HLD} phase_t;

    typedef struct {
        logic        wr;
        logic        io;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  addata;
        int          d;
        logic [7:0]  exp_rd;
        logic        exp_to;
        int          exp_ack;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i8088_bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    i8088_bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

    i8088_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT))
        u_dut (.clk(clk), .reset(reset), .bus(bus));
    i8088_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(0))
        u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    assign bus0.req_valid = bus.req_valid;
    assign bus0.req_wr    = bus.req_wr;
    assign bus0.req_io    = bus.req_io;
    assign bus0.req_addr  = bus.req_addr;
    assign bus0.req_wdata = bus.req_wdata;
    assign bus0.ad_in     = bus.ad_in;
    assign bus0.ready     = bus.ready;
    assign bus0.hold      = bus.hold;

    int   n_cmp = 0;
    int   n_err = 0;
    logic last_wr = 1'b0;
    logic last_io = 1'b0;
    logic [7:0] model_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
        return 32'({bus.ale, bus.rd_n, bus.wr_n, bus.den, bus.ad_oe, bus.iom, bus.dtr,
                    bus.ack, bus.timeout, bus.hlda, bus.bus_oe, bus.req_rdy});
    endfunction

    // Expected control pins for a bus phase, straight from the pin table of each T-state.
    function automatic logic [31:0] exp_ctrl(input phase_t p, input logic wr, input logic io,
                                             input logic to, input logic hold);
        logic ale, rd_n, wr_n, den, oe, ack, tmo, hlda, boe, rdy;
        ale = 0; rd_n = 1; wr_n = 1; den = 1; oe = 0; ack = 0; tmo = 0; hlda = 0; boe = 1; rdy = 0;
        case (p)
            P_T1:          begin ale = 1; oe = 1; end
            P_T2, P_WAIT:  begin den = 0; oe = wr; rd_n = wr; wr_n = !wr; end
            P_T4:          begin ack = 1; tmo = to; rdy = !hold; end
            P_IDLE:        rdy = !hold;
            P_HLD:         begin hlda = 1; boe = 0; end
            default: ;
        endcase
        return 32'({ale, rd_n, wr_n, den, oe, io, wr, ack, tmo, hlda, boe, rdy});
    endfunction

    // One transfer from IDLE; READY rises after d wait-phase cycles (never if d > MAX_WAIT).
    task automatic run_txn(input logic wr, input logic io, input logic [19:0] addr,
                           input logic [7:0] wdata, input logic [7:0] addata, input int d,
                           output int ack_cyc, output logic [7:0] rd, output logic to);
        int     ntw;
        int     j;
        phase_t ph;
        ntw = (d > int'(MAX_WAIT)) ? int'(MAX_WAIT) : d;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_io    = io;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        check("rdy_idle", 32'(bus.req_rdy), 32'd1);
        step();
        bus.req_valid = 1'b0;
        bus.req_wr    = ~wr;
        bus.req_io    = ~io;
        bus.req_addr  = 20'($urandom);
        bus.req_wdata = 8'($urandom);
        ack_cyc = 0;
        to = 1'b0;
        for (int c = 1; c <= 4 + ntw; c++) begin
            if (c == 1)             ph = P_T1;
            else if (c == 2)        ph = P_T2;
            else if (c == 4 + ntw)  ph = P_T4;
            else                    ph = P_WAIT;
            j = c - 3;
            if (ph == P_WAIT) begin
                bus.ready = (j >= d);
                bus.ad_in = (j >= d) ? addata : ~addata;
            end else begin
                bus.ready = 1'($urandom);
                bus.ad_in = 8'($urandom);
            end
            check("ctrl", obs(), exp_ctrl(ph, wr, io, d > int'(MAX_WAIT), 1'b0));
            if (ph == P_T1) begin
                check("addr_hi", 32'(bus.addr_hi), 32'(addr[19:8]));
                check("ad_addr", 32'(bus.ad_out), 32'(addr[7:0]));
            end
            if (ph == P_WAIT && wr) check("ad_wdata", 32'(bus.ad_out), 32'(wdata));
            if (bus.ack) begin
                ack_cyc = c;
                to = bus.timeout;
            end
            step();
        end
        bus.ready = 1'b0;
        rd = bus.rdata;
        last_wr = wr;
        last_io = io;
    endtask

    vec_t       vecs[5];
    int         ack_cyc;
    logic [7:0] rd;
    logic       to;

    initial begin
        reset = 1'b1;
        bus.req_valid = 0; bus.req_wr = 0; bus.req_io = 0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.ad_in = '0; bus.ready = 0; bus.hold = 0;
        step(); step();
        check("reset_ctrl", obs(), RESET_CTRL);
        check("reset_rdata", 32'(bus.rdata), 32'd0);
        check("reset_addr", 32'({bus.addr_hi, bus.ad_out}), 32'd0);
        reset = 1'b0;
        step();
        check("idle_ctrl", obs(), exp_ctrl(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));

        // Directed vectors with hand-derived completion values.
        vecs[0] = '{1'b0, 1'b0, 20'h81234, 8'h00, 8'hA5, 0,  8'hA5, 1'b0, 4};
        vecs[1] = '{1'b1, 1'b1, 20'h0FF05, 8'h3C, 8'h00, 0,  8'hA5, 1'b0, 4};
        vecs[2] = '{1'b0, 1'b0, 20'h12345, 8'h00, 8'h5A, 3,  8'h5A, 1'b0, 7};
        vecs[3] = '{1'b0, 1'b0, 20'h0AAAA, 8'h00, 8'h77, 99, 8'hFF, 1'b1, 19};
        vecs[4] = '{1'b0, 1'b1, 20'h00310, 8'h00, 8'hC3, 15, 8'hC3, 1'b0, 19};
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].wr, vecs[i].io, vecs[i].addr, vecs[i].wdata, vecs[i].addata,
                    vecs[i].d, ack_cyc, rd, to);
            check("vec_ack_cycle", 32'(ack_cyc), 32'(vecs[i].exp_ack));
            check("vec_rdata", 32'(rd), 32'(vecs[i].exp_rd));
            check("vec_timeout", 32'(to), 32'(vecs[i].exp_to));
            if (!vecs[i].wr) model_rdata = vecs[i].exp_rd;
        end

        // HOLD raised in T2 with a second request pending.
        bus.req_valid = 1; bus.req_wr = 0; bus.req_io = 0; bus.req_addr = 20'h45678;
        step();
        check("h_t1", obs(), exp_ctrl(P_T1, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.req_wr = 1; bus.req_addr = 20'hBCDEF; bus.req_wdata = 8'h5E;
        step();
        bus.hold = 1;
        check("h_t2", obs(), exp_ctrl(P_T2, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        bus.ready = 1; bus.ad_in = 8'h11;
        check("h_t3", obs(), exp_ctrl(P_WAIT, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        bus.ready = 0;
        check("h_t4", obs(), exp_ctrl(P_T4, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        check("h_hld1", obs(), exp_ctrl(P_HLD, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        check("h_hld2", obs(), exp_ctrl(P_HLD, 1'b0, 1'b0, 1'b0, 1'b1));
        bus.hold = 0;
        step();
        check("h_idle", obs(), exp_ctrl(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        bus.req_valid = 0;
        check("h2_t1", obs(), exp_ctrl(P_T1, 1'b1, 1'b0, 1'b0, 1'b0));
        check("h2_addr", 32'({bus.addr_hi, bus.ad_out}), 32'h000BCDEF);
        step();
        check("h2_t2", obs(), exp_ctrl(P_T2, 1'b1, 1'b0, 1'b0, 1'b0));
        bus.ready = 1;
        step();
        check("h2_t3_data", 32'(bus.ad_out), 32'h5E);
        step();
        bus.ready = 0;
        check("h2_t4", obs(), exp_ctrl(P_T4, 1'b1, 1'b0, 1'b0, 1'b0));
        check("h_rdata", 32'(bus.rdata), 32'h11);
        model_rdata = 8'h11; last_wr = 1; last_io = 0;
        step();

        // Back-to-back reads with REQ_VALID held across the first T4.
        bus.req_valid = 1; bus.req_wr = 0; bus.req_io = 0; bus.req_addr = 20'h00111;
        bus.ready = 1; bus.ad_in = 8'h21;
        step();
        for (int c = 1; c <= 8; c++) begin
            phase_t ph;
            case ((c - 1) % 4)
                0: ph = P_T1;
                1: ph = P_T2;
                2: ph = P_WAIT;
                default: ph = P_T4;
            endcase
            if (c == 5) bus.req_valid = 0;
            if (c == 4) check("b2b_t4a", obs(), exp_ctrl(P_T4, 1'b0, 1'b0, 1'b0, 1'b0));
            else        check("b2b_ctrl", obs() & 32'hFFE, exp_ctrl(ph, 1'b0, 1'b0, 1'b0, 1'b0) & 32'hFFE);
            step();
        end
        check("b2b_idle", obs(), exp_ctrl(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        check("b2b_rdata", 32'(bus.rdata), 32'h21);
        bus.ready = 0;
        model_rdata = 8'h21; last_wr = 0; last_io = 0;

        // Randomized transfers against the phase-level model.
        for (int n = 0; n < 40; n++) begin
            logic        wr, io;
            logic [19:0] addr;
            logic [7:0]  wd, ad;
            int          d, ntw;
            wr = 1'($urandom); io = 1'($urandom); addr = 20'($urandom);
            wd = 8'($urandom); ad = 8'($urandom);
            d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 4));
            ntw = (d > int'(MAX_WAIT)) ? int'(MAX_WAIT) : d;
            run_txn(wr, io, addr, wd, ad, d, ack_cyc, rd, to);
            if (!wr) model_rdata = (d > int'(MAX_WAIT)) ? 8'hFF : ad;
            check("rnd_ack_cycle", 32'(ack_cyc), 32'(4 + ntw));
            check("rnd_timeout", 32'(to), 32'(d > int'(MAX_WAIT)));
            check("rnd_rdata", 32'(rd), 32'(model_rdata));
            check("rnd_idle", obs(), exp_ctrl(P_IDLE, last_wr, last_io, 1'b0, 1'b0));
        end

        // Reset asserted while waiting in TW drops the transfer.
        bus.req_valid = 1; bus.req_wr = 0; bus.req_io = 1; bus.req_addr = 20'h22222;
        step();
        bus.req_valid = 0; bus.ready = 0;
        step(); step(); step();
        check("rt_tw", obs(), exp_ctrl(P_WAIT, 1'b0, 1'b1, 1'b0, 1'b0));
        reset = 1;
        step();
        check("rt_ctrl", obs(), RESET_CTRL);
        check("rt_rdata", 32'(bus.rdata), 32'd0);
        reset = 0;
        bus.ready = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("rt_quiet", obs(), exp_ctrl(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        bus.ready = 0;

        // MAX_WAIT=0 instance: T3 without READY goes straight to a timed-out T4.
        bus.req_valid = 1; bus.req_wr = 0; bus.req_io = 0; bus.req_addr = 20'h33333;
        check("mw0_rdy", 32'(bus0.req_rdy), 32'd1);
        step();
        bus.req_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            check("mw0_ack", 32'({bus0.ack, bus0.timeout}), (c == 4) ? 32'd3 : 32'd0);
            step();
        end
        check("mw0_rdata", 32'(bus0.rdata), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
